race_level_ctrl: RTL and testbench
==================================

RACE_LEVEL_CTRL -- requirements
Module: race_level_ctrl

Interface
REQ-001 SHALL have parameter FRAMES_PER_LEVEL, default 600: frame ticks per level, range 2..65535.
REQ-002 SHALL have parameter NUM_LEVELS, default 4: highest level index is NUM_LEVELS-1, range 1..4.
REQ-003 SHALL have parameter START_LIVES, default 3: lives at game start, range 1..3.
REQ-004 SHALL have parameter CRASH_FRAMES, default 120: frame ticks spent in CRASH, range 1..65535.
REQ-005 SHALL have port vga_clk, input, 1: pixel clock, the only clock.
REQ-006 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-007 SHALL have port v_sync, input, 1: vertical sync from the timing generator, active-low pulse, synchronous to vga_clk.
REQ-008 SHALL have port start_i, input, 1: level-sensitive start request.
REQ-009 SHALL have port pause_i, input, 1: freeze gameplay while high.
REQ-010 SHALL have port collision_i, input, 1: player/traffic overlap flag.
REQ-011 SHALL have port level_o, output, 2: current level to road and traffic generators.
REQ-012 SHALL have port state_o, output, 2: game state encoding.
REQ-013 SHALL have port lives_o, output, 2: remaining lives.
REQ-014 SHALL have port score_o, output, 16: frames survived, saturating.
REQ-015 SHALL have port scroll_en_o, output, 1: road/traffic animation enable.
REQ-016 SHALL have port frame_tick_o, output, 1: one-cycle pulse per frame.

Function
REQ-017 SHALL register v_sync into v_sync_q; internal tick = v_sync_q AND NOT v_sync (falling edge); frame_tick_o SHALL be tick registered, high exactly one cycle, one cycle after the edge sample.
REQ-018 SHALL implement states IDLE=0, RUN=1, CRASH=2, OVER=3, driven on state_o.
REQ-019 IDLE or OVER with start_i high SHALL go to RUN next cycle, loading level 0, lives START_LIVES, score 0, frame count 0.
REQ-020 RUN, tick, pause_i low: frame count +1, score +1 saturating at 0xFFFF.
REQ-021 RUN: when a tick arrives with frame count = FRAMES_PER_LEVEL-1, frame count SHALL clear and level SHALL increment, holding at NUM_LEVELS-1 (no wrap).
REQ-022 RUN with pause_i high SHALL freeze frame count, score and level and drop scroll_en_o; collision_i SHALL still be honoured.
REQ-023 RUN with collision_i high: lives -1; if lives was 1, go to OVER with lives 0; otherwise go to CRASH with crash count cleared.
REQ-024 Collision and tick in the same RUN cycle: the collision SHALL win, and the tick SHALL NOT advance score or frame count.
REQ-025 CRASH SHALL count ticks regardless of pause_i and return to RUN on the tick where crash count = CRASH_FRAMES-1; frame count, level and score are preserved.
REQ-026 collision_i SHALL be ignored outside RUN; start_i SHALL be ignored in RUN and CRASH.
REQ-027 scroll_en_o SHALL be high only in RUN with pause_i low; it is registered, following state by one cycle.
REQ-028 All outputs SHALL be registered; level_o SHALL change only on a tick edge or on a start.

Reset
REQ-029 rst_n low SHALL asynchronously force: state IDLE, level_o 0, lives_o START_LIVES, score_o 0, scroll_en_o 0, frame_tick_o 0, v_sync_q 1, all counters 0.
REQ-030 Reset asserted mid-RUN or mid-CRASH SHALL abandon the game; after release the block stays in IDLE until start_i.

Structure
REQ-031 Shared package race_pkg SHALL hold the state encoding constants and the parameter defaults.
REQ-032 Edge detection and the frame_tick_o register SHALL be a sub-module, frame_tick_gen.
REQ-033 Counters: 16-bit frame count and 16-bit crash count; no multipliers.

Verification (bench params: FRAMES_PER_LEVEL=4, NUM_LEVELS=4, START_LIVES=3, CRASH_FRAMES=2)
REQ-034 Reset then 3 v_sync pulses with no start -> state_o 0, score_o 0, scroll_en_o 0, frame_tick_o pulses 3 times.
REQ-035 start_i, then 17 ticks -> level_o steps 0,1,2,3 at ticks 4, 8 and 12, then holds at 3; score_o 17.
REQ-036 At score 5, assert collision_i in the same cycle as the tick edge -> state_o 2, lives_o 2, score_o stays 5; RUN resumes after 2 ticks with level_o 1.
REQ-037 Three collisions separated by the crash recovery -> lives_o 2, 1, 0; state_o 3; start_i -> RUN with lives_o 3, level_o 0, score_o 0.
REQ-038 pause_i high for 5 ticks in RUN -> score_o and level_o unchanged, scroll_en_o 0; collision during pause -> CRASH.
REQ-039 rst_n low during CRASH -> immediately state_o 0, lives_o 3, level_o 0, and the block stays in IDLE.

Source files
------------

// File: rtl/race_pkg.sv
// Shared definitions for the race game level controller.
// Holds the state encoding, parameter defaults and a saturating increment.
package race_pkg;

    localparam int FRAMES_PER_LEVEL_DEF = 600;
    localparam int NUM_LEVELS_DEF       = 4;
    localparam int START_LIVES_DEF      = 3;
    localparam int CRASH_FRAMES_DEF     = 120;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CRASH = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/race_level_ctrl_frame_tick_gen.sv
// Detects the falling edge of v_sync and produces the frame tick.
// tick is the raw edge strobe; frame_tick_o is its registered copy.
module frame_tick_gen (
    input  logic vga_clk,
    input  logic rst_n,
    input  logic v_sync,
    output logic tick,
    output logic frame_tick_o
);

    logic v_sync_q;

    assign tick = v_sync_q & ~v_sync;

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            v_sync_q     <= 1'b1;
            frame_tick_o <= 1'b0;
        end else begin
            v_sync_q     <= v_sync;
            frame_tick_o <= tick;
        end
    end

endmodule

// File: rtl/race_level_ctrl.sv
// Game flow controller: start, level progression, lives, crash recovery.
// All outputs are registered; gameplay advances on the v_sync falling edge.
module race_level_ctrl
    import race_pkg::*;
#(
    parameter int FRAMES_PER_LEVEL = FRAMES_PER_LEVEL_DEF,
    parameter int NUM_LEVELS       = NUM_LEVELS_DEF,
    parameter int START_LIVES      = START_LIVES_DEF,
    parameter int CRASH_FRAMES     = CRASH_FRAMES_DEF
) (
    input  logic        vga_clk,
    input  logic        rst_n,
    input  logic        v_sync,
    input  logic        start_i,
    input  logic        pause_i,
    input  logic        collision_i,
    output logic [1:0]  level_o,
    output logic [1:0]  state_o,
    output logic [1:0]  lives_o,
    output logic [15:0] score_o,
    output logic        scroll_en_o,
    output logic        frame_tick_o
);

    localparam logic [15:0] FRAME_LAST = 16'(FRAMES_PER_LEVEL - 1);
    localparam logic [15:0] CRASH_LAST = 16'(CRASH_FRAMES - 1);
    localparam logic [1:0]  LEVEL_MAX  = 2'(NUM_LEVELS - 1);
    localparam logic [1:0]  LIVES_INIT = 2'(START_LIVES);

    state_t      state;
    logic        tick;
    logic [15:0] frame_cnt;
    logic [15:0] crash_cnt;

    frame_tick_gen u_tick (
        .vga_clk      (vga_clk),
        .rst_n        (rst_n),
        .v_sync       (v_sync),
        .tick         (tick),
        .frame_tick_o (frame_tick_o)
    );

    assign state_o = state;

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            level_o     <= 2'd0;
            lives_o     <= LIVES_INIT;
            score_o     <= 16'd0;
            scroll_en_o <= 1'b0;
            frame_cnt   <= 16'd0;
            crash_cnt   <= 16'd0;
        end else begin
            scroll_en_o <= (state == ST_RUN) && !pause_i;
            unique case (state)
                ST_IDLE, ST_OVER: begin
                    if (start_i) begin
                        state     <= ST_RUN;
                        level_o   <= 2'd0;
                        lives_o   <= LIVES_INIT;
                        score_o   <= 16'd0;
                        frame_cnt <= 16'd0;
                        crash_cnt <= 16'd0;
                    end
                end
                ST_RUN: begin
                    // A collision swallows a coincident tick.
                    if (collision_i) begin
                        lives_o <= lives_o - 2'd1;
                        if (lives_o == 2'd1) begin
                            state <= ST_OVER;
                        end else begin
                            state     <= ST_CRASH;
                            crash_cnt <= 16'd0;
                        end
                    end else if (tick && !pause_i) begin
                        score_o <= sat_inc16(score_o);
                        if (frame_cnt == FRAME_LAST) begin
                            frame_cnt <= 16'd0;
                            if (level_o != LEVEL_MAX)
                                level_o <= level_o + 2'd1;
                        end else begin
                            frame_cnt <= frame_cnt + 16'd1;
                        end
                    end
                end
                ST_CRASH: begin
                    if (tick) begin
                        if (crash_cnt == CRASH_LAST) begin
                            state     <= ST_RUN;
                            crash_cnt <= 16'd0;
                        end else begin
                            crash_cnt <= crash_cnt + 16'd1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_race_level_ctrl.sv
// Self-checking bench for race_level_ctrl with a tick-counting reference model.
module tb_race_level_ctrl;

    localparam int FPL = 4;
    localparam int NL  = 4;
    localparam int SL  = 3;
    localparam int CF  = 2;

    logic        vga_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        v_sync = 1'b1;
    logic        start_i = 1'b0;
    logic        pause_i = 1'b0;
    logic        collision_i = 1'b0;
    logic [1:0]  level_o;
    logic [1:0]  state_o;
    logic [1:0]  lives_o;
    logic [15:0] score_o;
    logic        scroll_en_o;
    logic        frame_tick_o;

    int total = 0;
    int bad = 0;

    // Model: game progress is the number of counted run ticks.
    int m_state, m_lives, m_counted, m_crash;
    bit m_vsq, m_ftick, m_scroll;

    race_level_ctrl #(
        .FRAMES_PER_LEVEL (FPL),
        .NUM_LEVELS       (NL),
        .START_LIVES      (SL),
        .CRASH_FRAMES     (CF)
    ) dut (
        .vga_clk      (vga_clk),
        .rst_n        (rst_n),
        .v_sync       (v_sync),
        .start_i      (start_i),
        .pause_i      (pause_i),
        .collision_i  (collision_i),
        .level_o      (level_o),
        .state_o      (state_o),
        .lives_o      (lives_o),
        .score_o      (score_o),
        .scroll_en_o  (scroll_en_o),
        .frame_tick_o (frame_tick_o)
    );

    always #5 vga_clk = ~vga_clk;

    function automatic int exp_level();
        int l = m_counted / FPL;
        return (l > NL - 1) ? NL - 1 : l;
    endfunction

    function automatic int exp_score();
        return (m_counted > 65535) ? 65535 : m_counted;
    endfunction

    task automatic model_reset();
        m_state = 0; m_lives = SL; m_counted = 0; m_crash = 0;
        m_vsq = 1'b1; m_ftick = 1'b0; m_scroll = 1'b0;
    endtask

    task automatic cycle(input bit vs, input bit st, input bit pa, input bit co);
        bit tk;
        v_sync = vs; start_i = st; pause_i = pa; collision_i = co;
        tk = m_vsq && !vs;
        m_vsq = vs;
        m_ftick = tk;
        m_scroll = (m_state == 1) && !pa;
        if (m_state == 0 || m_state == 3) begin
            if (st) begin
                m_state = 1; m_lives = SL; m_counted = 0;
            end
        end else if (m_state == 1) begin
            if (co) begin
                m_lives--;
                if (m_lives == 0) m_state = 3;
                else begin m_state = 2; m_crash = 0; end
            end else if (tk && !pa) begin
                m_counted++;
            end
        end else if (tk) begin
            m_crash++;
            if (m_crash == CF) m_state = 1;
        end
        @(posedge vga_clk);
        #1;
    endtask

    task automatic frame(input bit pa, input bit co);
        cycle(1'b0, 1'b0, pa, co);
        cycle(1'b1, 1'b0, pa, 1'b0);
        cycle(1'b1, 1'b0, pa, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        v_sync = 1'b1; start_i = 1'b0; pause_i = 1'b0; collision_i = 1'b0;
        model_reset();
        @(posedge vga_clk);
        #1;
        rst_n = 1'b1;
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (state_o !== 2'd0 || level_o !== 2'd0 || lives_o !== 2'd3 ||
            score_o !== 16'd0 || scroll_en_o !== 1'b0 || frame_tick_o !== 1'b0) begin
            bad++;
            $display("FAIL reset: st=%0d lv=%0d li=%0d sc=%0d se=%0b ft=%0b want 0 0 3 0 0 0",
                     state_o, level_o, lives_o, score_o, scroll_en_o, frame_tick_o);
        end
    endtask

    task automatic test_idle_ticks();
        int pulses = 0;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0);
            if (frame_tick_o === 1'b1) pulses++;
            cycle(1'b1, 1'b0, 1'b0, 1'b0);
            if (frame_tick_o === 1'b1) pulses++;
            cycle(1'b1, 1'b0, 1'b0, 1'b0);
            if (frame_tick_o === 1'b1) pulses++;
        end
        total++;
        if (pulses != 3) begin
            bad++;
            $display("FAIL idle_pulses: got %0d want 3", pulses);
        end
        total++;
        if (state_o !== 2'd0 || score_o !== 16'd0 || scroll_en_o !== 1'b0) begin
            bad++;
            $display("FAIL idle_state: st=%0d sc=%0d se=%0b want 0 0 0",
                     state_o, score_o, scroll_en_o);
        end
    endtask

    task automatic test_level_progression();
        int want;
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        total++;
        if (state_o !== 2'd1 || scroll_en_o !== 1'b1) begin
            bad++;
            $display("FAIL start_run: st=%0d se=%0b want 1 1", state_o, scroll_en_o);
        end
        for (int k = 1; k <= 17; k++) begin
            frame(1'b0, 1'b0);
            want = (k < 4) ? 0 : (k < 8) ? 1 : (k < 12) ? 2 : 3;
            total++;
            if (level_o !== 2'(want) || score_o !== 16'(k)) begin
                bad++;
                $display("FAIL level_step%0d: lv=%0d sc=%0d want %0d %0d",
                         k, level_o, score_o, want, k);
            end
        end
    endtask

    task automatic test_collision_tick();
        do_reset();
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) frame(1'b0, 1'b0);
        frame(1'b0, 1'b1);
        total++;
        if (state_o !== 2'd2 || lives_o !== 2'd2 || score_o !== 16'd5 || level_o !== 2'd1) begin
            bad++;
            $display("FAIL coll_tick: st=%0d li=%0d sc=%0d lv=%0d want 2 2 5 1",
                     state_o, lives_o, score_o, level_o);
        end
        frame(1'b0, 1'b0);
        total++;
        if (state_o !== 2'd2) begin
            bad++;
            $display("FAIL crash_hold: st=%0d want 2", state_o);
        end
        frame(1'b0, 1'b0);
        total++;
        if (state_o !== 2'd1 || level_o !== 2'd1 || score_o !== 16'd5) begin
            bad++;
            $display("FAIL crash_resume: st=%0d lv=%0d sc=%0d want 1 1 5",
                     state_o, level_o, score_o);
        end
        frame(1'b0, 1'b0);
        total++;
        if (score_o !== 16'd6) begin
            bad++;
            $display("FAIL after_resume: sc=%0d want 6", score_o);
        end
    endtask

    task automatic test_lives_over();
        int want_lives;
        do_reset();
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        frame(1'b0, 1'b0);
        for (int n = 1; n <= 3; n++) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b1);
            want_lives = 3 - n;
            total++;
            if (lives_o !== 2'(want_lives) || state_o !== ((n == 3) ? 2'd3 : 2'd2)) begin
                bad++;
                $display("FAIL collide%0d: li=%0d st=%0d want %0d %0d",
                         n, lives_o, state_o, want_lives, (n == 3) ? 3 : 2);
            end
            if (n == 1) begin
                cycle(1'b1, 1'b1, 1'b0, 1'b1);
                total++;
                if (state_o !== 2'd2 || lives_o !== 2'd2) begin
                    bad++;
                    $display("FAIL crash_ignore: st=%0d li=%0d want 2 2", state_o, lives_o);
                end
            end
            if (n < 3) begin
                frame(1'b0, 1'b0);
                frame(1'b0, 1'b0);
            end
        end
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        frame(1'b0, 1'b0);
        total++;
        if (state_o !== 2'd3 || lives_o !== 2'd0) begin
            bad++;
            $display("FAIL over_hold: st=%0d li=%0d want 3 0", state_o, lives_o);
        end
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        total++;
        if (state_o !== 2'd1 || lives_o !== 2'd3 || level_o !== 2'd0 || score_o !== 16'd0) begin
            bad++;
            $display("FAIL restart: st=%0d li=%0d lv=%0d sc=%0d want 1 3 0 0",
                     state_o, lives_o, level_o, score_o);
        end
    endtask

    task automatic test_pause();
        do_reset();
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) frame(1'b0, 1'b0);
        for (int k = 0; k < 5; k++) frame(1'b1, 1'b0);
        total++;
        if (score_o !== 16'd5 || level_o !== 2'd1 || scroll_en_o !== 1'b0 || state_o !== 2'd1) begin
            bad++;
            $display("FAIL pause_freeze: sc=%0d lv=%0d se=%0b st=%0d want 5 1 0 1",
                     score_o, level_o, scroll_en_o, state_o);
        end
        cycle(1'b1, 1'b0, 1'b1, 1'b1);
        total++;
        if (state_o !== 2'd2 || lives_o !== 2'd2) begin
            bad++;
            $display("FAIL pause_collide: st=%0d li=%0d want 2 2", state_o, lives_o);
        end
    endtask

    task automatic test_reset_in_crash();
        do_reset();
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) frame(1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (state_o !== 2'd0 || lives_o !== 2'd3 || level_o !== 2'd0) begin
            bad++;
            $display("FAIL async_reset: st=%0d li=%0d lv=%0d want 0 3 0",
                     state_o, lives_o, level_o);
        end
        model_reset();
        @(posedge vga_clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) frame(1'b0, 1'b0);
        total++;
        if (state_o !== 2'd0 || score_o !== 16'd0 || scroll_en_o !== 1'b0) begin
            bad++;
            $display("FAIL stay_idle: st=%0d sc=%0d se=%0b want 0 0 0",
                     state_o, score_o, scroll_en_o);
        end
    endtask

    task automatic test_random();
        bit vs, st, pa, co;
        int errs = 0;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            vs = ($urandom_range(0, 2) != 0);
            st = ($urandom_range(0, 7) == 0);
            pa = ($urandom_range(0, 3) == 0);
            co = ($urandom_range(0, 15) == 0);
            cycle(vs, st, pa, co);
            total++;
            if (state_o !== 2'(m_state) || lives_o !== 2'(m_lives) ||
                level_o !== 2'(exp_level()) || score_o !== 16'(exp_score()) ||
                scroll_en_o !== m_scroll || frame_tick_o !== m_ftick) begin
                bad++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random%0d: st=%0d li=%0d lv=%0d sc=%0d se=%0b ft=%0b want %0d %0d %0d %0d %0b %0b",
                             i, state_o, lives_o, level_o, score_o, scroll_en_o, frame_tick_o,
                             m_state, m_lives, exp_level(), exp_score(), m_scroll, m_ftick);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_idle_ticks();
        test_level_progression();
        test_collision_tick();
        test_lives_over();
        test_pause();
        test_reset_in_crash();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
